alk_muldiv_seq: RTL and testbench
=================================

ALK_MULDIV_SEQ -- requirements
Module: alk_muldiv_seq

Interface
REQ-001 Reset is synchronous and active-low; the block uses one clock.
REQ-002 clk  input  1  Single microcycle clock; all state updates on the rising edge.
REQ-003 reset_l  input  1  Synchronous active-low reset.
REQ-004 start_h  input  1  Decoded ALPCTL mul/div micro-op is issued this cycle; sampled only in IDLE.
REQ-005 mul_l  input  1  Active-low: the op is a multiply.
REQ-006 div_l  input  1  Active-low: the op is a divide.
REQ-007 divdbl_l  input  1  Active-low: the op is a double-length divide (64-bit dividend).
REQ-008 rem_l  input  1  Active-low: remainder is required; adds a correction step.
REQ-009 dblclk_h  input  1  Two datapath steps are taken per cycle (fast mul/div).
REQ-010 dsize_h  input  2  Operand size: 00 byte, 01 word, 10 long, 11 long.
REQ-011 stall_l  input  1  Active-low microcycle stall; freezes the sequencer.
REQ-012 abort_h  input  1  Cancel the operation in progress.
REQ-013 step_h  output  1  Datapath performs a shift/add-subtract step this cycle.
REQ-014 loop_flag_h  output  1  Current step cycle is the final iteration; feeds the ALK loop_flag_h input.
REQ-015 fixup_h  output  1  Divide restore/correction cycle is active.
REQ-016 busy_h  output  1  Sequencer is not IDLE.
REQ-017 done_h  output  1  One-cycle pulse on completion.
REQ-018 count_h  output  7  Remaining step count.

Function
REQ-019 States: IDLE, RUN, FIXUP, DONE; encoded in 2 bits.
REQ-020 IDLE to RUN when start_h=1 and stall_l=1; count_h loads N on the same edge.
- N = 8/16/32 for dsize 00/01/1x.
- N doubles when divdbl_l=0, giving a maximum of 64.
- start_h is ignored when mul_l and div_l are both 1.
- When mul_l and div_l are both 0, multiply wins.
REQ-021 The op class (mul/div/rem/divdbl) and dblclk_h are latched at start and held until the return to IDLE.
REQ-022 Step size S = 2 if the latched dblclk_h=1, else 1.
REQ-023 In RUN with stall_l=1: step_h=1 and count_h decrements by S.
REQ-024 In RUN, loop_flag_h=1 combinationally when count_h<=S.
REQ-025 RUN exit on a loop_flag_h cycle with stall_l=1:
- to FIXUP if the latched op is a divide, or rem_l was 0;
- otherwise to DONE.
REQ-026 FIXUP lasts exactly one unstalled cycle with fixup_h=1 and step_h=0, then goes to DONE.
REQ-027 DONE lasts one cycle with done_h=1, then goes to IDLE; busy_h=0 only in IDLE.
REQ-028 stall_l=0 freezes state and count_h. While stalled, step_h=0 and done_h=0; fixup_h and loop_flag_h stay at their state-derived values.
REQ-029 abort_h=1 forces IDLE on the next edge from any state, with count_h=0 and no done_h pulse. abort_h takes priority over stall_l and start_h.
REQ-030 count_h saturates at 0 and never wraps.
- An odd N with S=2 is impossible by construction.
- If an odd N with S=2 does occur, the final decrement clamps to 0.
REQ-031 Total latency from start to done_h, unstalled:
- mul: N/S+1 cycles;
- div/rem: N/S+2 cycles.
REQ-032 A start_h asserted in DONE is ignored. The earliest back-to-back start is the IDLE cycle after DONE.

Reset
REQ-033 While reset_l=0 at an edge, the block enters IDLE with count_h=0 and the latched op cleared. All outputs are then 0.
REQ-034 Reset mid-operation discards the operation, produces no done_h pulse, and takes priority over abort_h and start_h.

Structure
REQ-035 The state encoding and the step-count constants (8/16/32/64) belong in the shared ALK definitions header alongside the ucode field definitions.
REQ-036 One natural sub-module, alk_muldiv_cnt, is permitted: the load/decrement-by-S saturating counter with a last-step compare.
REQ-037 All other logic (state register, op latch, output decode) shall be flat in alk_muldiv_seq.

Verification
REQ-038 Long multiply: dsize=10, mul_l=0, dblclk_h=0, start pulse -> step_h high 32 cycles, loop_flag_h on the 32nd, done_h 33 cycles after start, count_h 32->0.
REQ-039 Fast word divide: dsize=01, div_l=0, dblclk_h=1 -> 8 step cycles (count 16,14,...,2), loop_flag_h at count 2, one fixup_h cycle, then done_h.
REQ-040 Double divide: dsize=10, divdbl_l=0, rem_l=0 -> count loads 64, 64 step cycles, FIXUP, DONE at cycle 66.
REQ-041 Stall mid-run: byte multiply, stall_l=0 for 3 cycles at count 5 -> count_h holds 5 and step_h=0 for 3 cycles; total latency 9+3=12 cycles.
REQ-042 Abort and reset: abort_h at count 10 of a long multiply -> IDLE next cycle, count_h=0, no done_h. reset_l=0 during FIXUP -> IDLE, all outputs 0.
REQ-043 Ignored starts: start_h while busy_h=1 -> no effect on count_h. start_h with mul_l=div_l=1 -> remains IDLE.

Source files
------------

// File: rtl/alk_muldiv_seq_pkg.sv
// Shared ALK mul/div sequencer definitions: state encoding, step-count constants, op decode.
package alk_muldiv_seq_pkg;

  localparam int unsigned CNT_W  = 7;
  localparam int unsigned N_BYTE = 8;
  localparam int unsigned N_WORD = 16;
  localparam int unsigned N_LONG = 32;
  localparam int unsigned N_DBL  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_MUL    = 2'd1,
    OP_DIV    = 2'd2,
    OP_DIVDBL = 2'd3
  } op_cls_t;

  typedef struct packed {
    op_cls_t cls;
    logic    rem;
    logic    dblclk;
  } op_t;

  // Iteration count for an operand size; a double-length op doubles it.
  function automatic logic [CNT_W-1:0] step_count(input logic [1:0] dsize, input logic divdbl_l);
    logic [CNT_W-1:0] n;
    unique case (dsize)
      2'b00:   n = divdbl_l ? CNT_W'(N_BYTE) : CNT_W'(N_WORD);
      2'b01:   n = divdbl_l ? CNT_W'(N_WORD) : CNT_W'(N_LONG);
      default: n = divdbl_l ? CNT_W'(N_LONG) : CNT_W'(N_DBL);
    endcase
    return n;
  endfunction

  // Op class from the active-low micro-op bits; multiply wins over divide.
  function automatic op_cls_t decode_op(input logic mul_l, input logic div_l, input logic divdbl_l);
    op_cls_t cls;
    if (!mul_l)      cls = OP_MUL;
    else if (!div_l) cls = divdbl_l ? OP_DIV : OP_DIVDBL;
    else             cls = OP_NONE;
    return cls;
  endfunction

endpackage

// File: rtl/alk_muldiv_seq_cnt.sv
// Load / decrement-by-S saturating step counter with last-step compare.
module alk_muldiv_cnt
  import alk_muldiv_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clr_h,
  input  logic             load_h,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_h,
  input  logic             step2_h,
  output logic [CNT_W-1:0] count,
  output logic             last_c
);

  logic [CNT_W-1:0] step_sz;

  assign step_sz = step2_h ? CNT_W'(2) : CNT_W'(1);
  assign last_c  = (count <= step_sz);

  // Counter register: clear, load N, or step down clamping at zero.
  always_ff @(posedge clk) begin
    if (!reset_l || clr_h)
      count <= '0;
    else if (load_h)
      count <= load_val;
    else if (dec_h)
      count <= last_c ? '0 : count - step_sz;
  end

endmodule

// File: rtl/alk_muldiv_seq.sv
// ALK multiply/divide microcycle sequencer: drives step/loop/fixup/done for the datapath.
module alk_muldiv_seq
  import alk_muldiv_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start_h,
  input  logic             mul_l,
  input  logic             div_l,
  input  logic             divdbl_l,
  input  logic             rem_l,
  input  logic             dblclk_h,
  input  logic [1:0]       dsize_h,
  input  logic             stall_l,
  input  logic             abort_h,
  output logic             step_h,
  output logic             loop_flag_h,
  output logic             fixup_h,
  output logic             busy_h,
  output logic             done_h,
  output logic [CNT_W-1:0] count_h
);

  state_t  state;
  state_t  state_nxt;
  op_t     op_q;
  op_cls_t op_cls_c;
  logic    accept_c;
  logic    dec_c;
  logic    last_c;
  logic    to_fixup_c;

  assign op_cls_c   = decode_op(mul_l, div_l, divdbl_l);
  assign accept_c   = (state == ST_IDLE) && start_h && stall_l && !abort_h && (op_cls_c != OP_NONE);
  assign dec_c      = (state == ST_RUN) && stall_l && !abort_h;
  assign to_fixup_c = (op_q.cls != OP_MUL) || op_q.rem;

  alk_muldiv_cnt u_cnt (
    .clk      (clk),
    .reset_l  (reset_l),
    .clr_h    (abort_h),
    .load_h   (accept_c),
    .load_val (step_count(dsize_h, divdbl_l)),
    .dec_h    (dec_c),
    .step2_h  (op_q.dblclk),
    .count    (count_h),
    .last_c   (last_c)
  );

  // Op latch: captured at start, held until the sequencer returns to IDLE.
  always_ff @(posedge clk) begin
    if (!reset_l || abort_h)
      op_q <= '0;
    else if (accept_c) begin
      op_q.cls    <= op_cls_c;
      op_q.rem    <= !rem_l;
      op_q.dblclk <= dblclk_h;
    end
    else if ((state == ST_DONE) && stall_l)
      op_q <= '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_l)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state: abort wins, stall freezes every transition.
  always_comb begin
    state_nxt = state;
    if (abort_h)
      state_nxt = ST_IDLE;
    else begin
      unique case (state)
        ST_IDLE:  if (accept_c)          state_nxt = ST_RUN;
        ST_RUN:   if (stall_l && last_c) state_nxt = to_fixup_c ? ST_FIXUP : ST_DONE;
        ST_FIXUP: if (stall_l)           state_nxt = ST_DONE;
        ST_DONE:  if (stall_l)           state_nxt = ST_IDLE;
        default:                         state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from state; step and done are suppressed while stalled or aborting.
  always_comb begin
    step_h      = 1'b0;
    loop_flag_h = 1'b0;
    fixup_h     = 1'b0;
    done_h      = 1'b0;
    busy_h      = (state != ST_IDLE);
    unique case (state)
      ST_RUN: begin
        step_h      = stall_l && !abort_h;
        loop_flag_h = last_c;
      end
      ST_FIXUP: fixup_h = 1'b1;
      ST_DONE:  done_h  = stall_l && !abort_h;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_alk_muldiv_seq.sv
// Self-checking bench for alk_muldiv_seq against a per-cycle expected-trace model.
module tb_alk_muldiv_seq;

  logic       clk = 1'b0;
  logic       reset_l, start_h, mul_l, div_l, divdbl_l, rem_l, dblclk_h, stall_l, abort_h;
  logic [1:0] dsize_h;
  logic       step_h, loop_flag_h, fixup_h, busy_h, done_h;
  logic [6:0] count_h;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit step;
    bit loop;
    bit fix;
    bit done;
    bit busy;
    int cnt;
  } exp_t;

  exp_t q[$];

  alk_muldiv_seq dut (
    .clk(clk), .reset_l(reset_l), .start_h(start_h), .mul_l(mul_l), .div_l(div_l),
    .divdbl_l(divdbl_l), .rem_l(rem_l), .dblclk_h(dblclk_h), .dsize_h(dsize_h),
    .stall_l(stall_l), .abort_h(abort_h), .step_h(step_h), .loop_flag_h(loop_flag_h),
    .fixup_h(fixup_h), .busy_h(busy_h), .done_h(done_h), .count_h(count_h)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".step"},  {7'd0, step_h},      8'(e.step));
    chk({tag, ".loop"},  {7'd0, loop_flag_h}, 8'(e.loop));
    chk({tag, ".fixup"}, {7'd0, fixup_h},     8'(e.fix));
    chk({tag, ".done"},  {7'd0, done_h},      8'(e.done));
    chk({tag, ".busy"},  {7'd0, busy_h},      8'(e.busy));
    chk({tag, ".count"}, {1'b0, count_h},     8'(e.cnt));
  endtask

  // One operation from the IDLE start cycle to the IDLE cycle after DONE.
  // mode: 0 no stall, 1 random stalls, 2 three-cycle stall at count 5.
  task automatic run_op(input string tag, input logic ml, input logic dl, input logic ddl,
                        input logic rl, input logic dbl, input logic [1:0] ds, input int mode);
    int   n, s, steps, t, stalls;
    bit   fix, stall;
    exp_t e;
    exp_t idle;
    idle = '{0, 0, 0, 0, 0, 0};
    n = (ds == 2'b00) ? 8 : (ds == 2'b01) ? 16 : 32;
    if (!ddl) n = n * 2;
    s     = dbl ? 2 : 1;
    steps = n / s;
    fix   = ml || !rl;
    q.delete();
    for (int i = 0; i < steps; i++)
      q.push_back('{1, (i == steps - 1), 0, 0, 1, n - i * s});
    if (fix) q.push_back('{0, 0, 1, 0, 1, 0});
    q.push_back('{0, 0, 0, 1, 1, 0});

    start_h = 1'b1; mul_l = ml; div_l = dl; divdbl_l = ddl; rem_l = rl;
    dblclk_h = dbl; dsize_h = ds; stall_l = 1'b1; abort_h = 1'b0;
    @(negedge clk);
    chk_all({tag, ".idle"}, idle);
    tick();
    t = 1; stalls = 0;
    for (int k = 0; k < 400 && q.size() > 0; k++) begin
      start_h  = 1'($urandom); mul_l = 1'($urandom); div_l = 1'($urandom);
      divdbl_l = 1'($urandom); rem_l = 1'($urandom); dblclk_h = 1'($urandom);
      dsize_h  = 2'($urandom);
      stall = 1'b0;
      if (mode == 1) stall = ($urandom_range(0, 5) == 0);
      if (mode == 2) stall = q[0].step && (q[0].cnt == 5) && (stalls < 3);
      stall_l = !stall;
      @(negedge clk);
      e = q[0];
      if (stall) begin e.step = 0; e.done = 0; end
      chk_all(tag, e);
      if (!stall && q[0].done)
        chk({tag, ".latency"}, 8'(t), 8'(steps + 1 + int'(fix) + stalls));
      tick();
      t++;
      if (stall) stalls++;
      else void'(q.pop_front());
    end
    chk({tag, ".timeout"}, 8'(q.size()), 8'd0);
    start_h = 1'b0; stall_l = 1'b1;
    @(negedge clk);
    chk_all({tag, ".end"}, idle);
    tick();
  endtask

  initial begin
    exp_t idle;
    idle = '{0, 0, 0, 0, 0, 0};
    reset_l = 1'b0; start_h = 1'b0; mul_l = 1'b1; div_l = 1'b1; divdbl_l = 1'b1;
    rem_l = 1'b1; dblclk_h = 1'b0; dsize_h = 2'b00; stall_l = 1'b1; abort_h = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk_all("reset", idle);
    tick();
    reset_l = 1'b1;
    tick();

    // Directed scenarios
    run_op("long_mul",   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 0);
    run_op("fast_wdiv",  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 0);
    run_op("dbl_div",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 0);
    run_op("stall_bmul", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2);
    run_op("both_low",   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 0);
    run_op("mul_rem",    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1);

    // Abort at count 10 of a long multiply
    start_h = 1'b1; mul_l = 1'b0; div_l = 1'b1; divdbl_l = 1'b1; rem_l = 1'b1;
    dblclk_h = 1'b0; dsize_h = 2'b10; stall_l = 1'b1;
    tick();
    start_h = 1'b0;
    for (int i = 0; i < 40 && count_h != 7'd10; i++) tick();
    chk("abort.reach10", {1'b0, count_h}, 8'd10);
    abort_h = 1'b1;
    tick();
    abort_h = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all("abort.after", idle);
      tick();
    end

    // Reset during FIXUP of a fast word divide
    start_h = 1'b1; mul_l = 1'b1; div_l = 1'b0; dblclk_h = 1'b1; dsize_h = 2'b01;
    tick();
    start_h = 1'b0;
    for (int i = 0; i < 40 && !fixup_h; i++) tick();
    chk("rst.reach_fixup", {7'd0, fixup_h}, 8'd1);
    reset_l = 1'b0;
    tick();
    @(negedge clk);
    chk_all("rst.in_reset", idle);
    reset_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk_all("rst.after", idle);
    end
    tick();

    // Start with neither mul nor div selected is ignored
    start_h = 1'b1; mul_l = 1'b1; div_l = 1'b1; divdbl_l = 1'b0; dsize_h = 2'b10;
    tick();
    start_h = 1'b0;
    @(negedge clk);
    chk_all("nop_start", idle);
    tick();

    // Randomized operations with random stalls
    for (int r = 0; r < 8; r++) begin
      logic ml, dl;
      ml = 1'($urandom);
      dl = ml ? 1'b0 : 1'($urandom);
      run_op($sformatf("rnd%0d", r), ml, dl, 1'($urandom), 1'($urandom),
             1'($urandom), 2'($urandom), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
